// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM. It sequences the PC, IR, register file, ALU and data memory
// for one instruction at a time. The outputs are decoded from the current state and op/funct.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pcwr,
  output logic             irwr,
  output logic [1:0]       npc_op,
  output logic             regwr,
  output logic [1:0]       regdst,
  output logic [1:0]       wd_sel,
  output logic             alusrc,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             memwr,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MA     = 4'd2,
    S_MR     = 4'd3,
    S_MW     = 4'd4,
    S_LWB    = 4'd5,
    S_EXE    = 4'd6,
    S_RWB    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9
  } state_t;

  state_t cur;
  state_t dcd;

  logic rtype;
  logic is_addu, is_subu, is_jr;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_alu, is_mem, is_jmp, supported;
  logic retire;

  assign rtype   = (op == 6'b000000);
  assign is_addu = rtype && (funct == 6'b100001);
  assign is_subu = rtype && (funct == 6'b100011);
  assign is_jr   = rtype && (funct == 6'b001000);
  assign is_ori  = (op == 6'b001101);
  assign is_lui  = (op == 6'b001111);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);

  assign is_alu    = is_addu | is_subu | is_ori | is_lui;
  assign is_mem    = is_lw | is_sw;
  assign is_jmp    = is_j | is_jal | is_jr;
  assign supported = is_alu | is_mem | is_jmp | is_beq;

  // Each of these states is the final cycle of a supported instruction.
  assign retire = (cur == S_LWB) || (cur == S_MW) || (cur == S_RWB) ||
                  (cur == S_BR)  || (cur == S_JMP);

  assign state = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_FETCH;
      instret <= '0;
    end else begin
      case (cur)
        S_FETCH:  cur <= S_DECODE;
        S_DECODE: begin
          if (is_mem)      cur <= S_MA;
          else if (is_alu) cur <= S_EXE;
          else if (is_beq) cur <= S_BR;
          else if (is_jmp) cur <= S_JMP;
          else             cur <= S_FETCH;
        end
        S_MA:     cur <= is_lw ? S_MR : S_MW;
        S_MR:     cur <= S_LWB;
        S_EXE:    cur <= S_RWB;
        default:  cur <= S_FETCH;
      endcase
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  // While reset is high, decode as FETCH. The write enables below are then masked off.
  assign dcd = reset ? S_FETCH : cur;

  always_comb begin
    pcwr    = 1'b0;
    irwr    = 1'b0;
    npc_op  = 2'b00;
    regwr   = 1'b0;
    regdst  = 2'b00;
    wd_sel  = 2'b00;
    alusrc  = 1'b0;
    alu_op  = 3'b000;
    ext_op  = 2'b00;
    memwr   = 1'b0;
    illegal = 1'b0;
    case (dcd)
      S_FETCH: begin
        pcwr = 1'b1;
        irwr = 1'b1;
      end
      S_DECODE: illegal = ~supported;
      S_MA, S_MR, S_MW: begin
        alusrc = 1'b1;
        ext_op = 2'b01;
        memwr  = (dcd == S_MW);
      end
      S_LWB: begin
        regwr  = 1'b1;
        wd_sel = 2'b01;
      end
      S_EXE, S_RWB: begin
        if (is_subu) begin
          alu_op = 3'b001;
        end else if (is_ori) begin
          alu_op = 3'b010;
          alusrc = 1'b1;
        end else if (is_lui) begin
          alu_op = 3'b011;
          alusrc = 1'b1;
          ext_op = 2'b10;
        end
        if (dcd == S_RWB) begin
          regwr  = 1'b1;
          regdst = rtype ? 2'b01 : 2'b00;
        end
      end
      S_BR: begin
        alu_op = 3'b001;
        npc_op = 2'b01;
        pcwr   = zero;
      end
      S_JMP: begin
        pcwr   = 1'b1;
        npc_op = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          regwr  = 1'b1;
          regdst = 2'b10;
          wd_sel = 2'b10;
        end
      end
      default: ;
    endcase
    if (reset) begin
      pcwr    = 1'b0;
      irwr    = 1'b0;
      regwr   = 1'b0;
      memwr   = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl. It walks each instruction class cycle by cycle and compares
// the full control word against hand-written constants. A CNT_W=4 copy covers instret wrap.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero;

  logic        pcwr, irwr, regwr, alusrc, memwr, illegal;
  logic [1:0]  npc_op, regdst, wd_sel, ext_op;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instret;

  logic        pcwr1, irwr1, regwr1, alusrc1, memwr1, illegal1;
  logic [1:0]  npc_op1, regdst1, wd_sel1, ext_op1;
  logic [2:0]  alu_op1;
  logic [3:0]  state1;
  logic [3:0]  instret1;

  logic [31:0] ctl;
  int n_chk = 0;
  int n_fail = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcwr(pcwr), .irwr(irwr), .npc_op(npc_op), .regwr(regwr), .regdst(regdst),
    .wd_sel(wd_sel), .alusrc(alusrc), .alu_op(alu_op), .ext_op(ext_op),
    .memwr(memwr), .illegal(illegal), .state(state), .instret(instret)
  );

  mc_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcwr(pcwr1), .irwr(irwr1), .npc_op(npc_op1), .regwr(regwr1), .regdst(regdst1),
    .wd_sel(wd_sel1), .alusrc(alusrc1), .alu_op(alu_op1), .ext_op(ext_op1),
    .memwr(memwr1), .illegal(illegal1), .state(state1), .instret(instret1)
  );

  // Bit order: pcwr irwr npc_op regwr regdst wd_sel alusrc alu_op ext_op memwr illegal
  assign ctl = {15'b0, pcwr, irwr, npc_op, regwr, regdst, wd_sel, alusrc, alu_op, ext_op,
                memwr, illegal};

  localparam logic [31:0] C_NONE  = 32'b0_0_00_0_00_00_0_000_00_0_0;
  localparam logic [31:0] C_FETCH = 32'b1_1_00_0_00_00_0_000_00_0_0;
  localparam logic [31:0] C_ILL   = 32'b0_0_00_0_00_00_0_000_00_0_1;
  localparam logic [31:0] C_MA    = 32'b0_0_00_0_00_00_1_000_01_0_0;
  localparam logic [31:0] C_MW    = 32'b0_0_00_0_00_00_1_000_01_1_0;
  localparam logic [31:0] C_LWB   = 32'b0_0_00_1_00_01_0_000_00_0_0;
  localparam logic [31:0] C_ADDR  = 32'b0_0_00_1_01_00_0_000_00_0_0;
  localparam logic [31:0] C_SUBE  = 32'b0_0_00_0_00_00_0_001_00_0_0;
  localparam logic [31:0] C_SUBR  = 32'b0_0_00_1_01_00_0_001_00_0_0;
  localparam logic [31:0] C_ORIE  = 32'b0_0_00_0_00_00_1_010_00_0_0;
  localparam logic [31:0] C_ORIR  = 32'b0_0_00_1_00_00_1_010_00_0_0;
  localparam logic [31:0] C_LUIE  = 32'b0_0_00_0_00_00_1_011_10_0_0;
  localparam logic [31:0] C_LUIR  = 32'b0_0_00_1_00_00_1_011_10_0_0;
  localparam logic [31:0] C_BRT   = 32'b1_0_01_0_00_00_0_001_00_0_0;
  localparam logic [31:0] C_BRN   = 32'b0_0_01_0_00_00_0_001_00_0_0;
  localparam logic [31:0] C_J     = 32'b1_0_10_0_00_00_0_000_00_0_0;
  localparam logic [31:0] C_JAL   = 32'b1_0_10_1_10_10_0_000_00_0_0;
  localparam logic [31:0] C_JR    = 32'b1_0_11_0_00_00_0_000_00_0_0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle (state and control word), then advance to the next cycle.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [31:0] c);
    chk({tag, ".state"}, {28'b0, state}, {28'b0, st});
    chk({tag, ".ctl"}, ctl, c);
    tick();
  endtask

  task automatic set_ins(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; zero = 1'b0;
    set_ins(6'b100011, 6'b0);
    tick();
    tick();
    chk("rst.state", {28'b0, state}, 32'd0);
    chk("rst.ctl", ctl, C_NONE);
    chk("rst.instret", instret, 32'd0);
    chk("rst.instret4", {28'b0, instret1}, 32'd0);
    reset = 1'b0;
    #1;

    // lw
    cyc("lw.f", 4'd0, C_FETCH);
    cyc("lw.d", 4'd1, C_NONE);
    cyc("lw.ma", 4'd2, C_MA);
    cyc("lw.mr", 4'd3, C_MA);
    chk("lw.ret_pre", instret, 32'd0);
    cyc("lw.wb", 4'd5, C_LWB);
    exp_ret = 1;
    chk("lw.instret", instret, exp_ret);

    // sw
    set_ins(6'b101011, 6'b0);
    cyc("sw.f", 4'd0, C_FETCH);
    cyc("sw.d", 4'd1, C_NONE);
    cyc("sw.ma", 4'd2, C_MA);
    cyc("sw.mw", 4'd4, C_MW);
    exp_ret++;

    // ALU group
    set_ins(6'b000000, 6'b100001);
    cyc("addu.f", 4'd0, C_FETCH); cyc("addu.d", 4'd1, C_NONE);
    cyc("addu.e", 4'd6, C_NONE);  cyc("addu.w", 4'd7, C_ADDR);
    set_ins(6'b000000, 6'b100011);
    cyc("subu.f", 4'd0, C_FETCH); cyc("subu.d", 4'd1, C_NONE);
    cyc("subu.e", 4'd6, C_SUBE);  cyc("subu.w", 4'd7, C_SUBR);
    set_ins(6'b001101, 6'b000000);
    cyc("ori.f", 4'd0, C_FETCH);  cyc("ori.d", 4'd1, C_NONE);
    cyc("ori.e", 4'd6, C_ORIE);   cyc("ori.w", 4'd7, C_ORIR);
    set_ins(6'b001111, 6'b100001);
    cyc("lui.f", 4'd0, C_FETCH);  cyc("lui.d", 4'd1, C_NONE);
    cyc("lui.e", 4'd6, C_LUIE);   cyc("lui.w", 4'd7, C_LUIR);
    exp_ret += 4;
    chk("alu.instret", instret, exp_ret);

    // beq taken / not taken
    set_ins(6'b000100, 6'b0);
    zero = 1'b1;
    cyc("beqt.f", 4'd0, C_FETCH); cyc("beqt.d", 4'd1, C_NONE); cyc("beqt.br", 4'd8, C_BRT);
    zero = 1'b0;
    cyc("beqn.f", 4'd0, C_FETCH); cyc("beqn.d", 4'd1, C_NONE); cyc("beqn.br", 4'd8, C_BRN);
    exp_ret += 2;
    chk("beq.instret", instret, exp_ret);

    // jumps
    set_ins(6'b000010, 6'b0);
    cyc("j.f", 4'd0, C_FETCH);   cyc("j.d", 4'd1, C_NONE);   cyc("j.j", 4'd9, C_J);
    set_ins(6'b000011, 6'b0);
    cyc("jal.f", 4'd0, C_FETCH); cyc("jal.d", 4'd1, C_NONE); cyc("jal.j", 4'd9, C_JAL);
    set_ins(6'b000000, 6'b001000);
    cyc("jr.f", 4'd0, C_FETCH);  cyc("jr.d", 4'd1, C_NONE);  cyc("jr.j", 4'd9, C_JR);
    exp_ret += 3;
    chk("jmp.instret", instret, exp_ret);

    // illegal op and illegal R-type funct: two cycles, no retire
    set_ins(6'b111111, 6'b0);
    cyc("ill.f", 4'd0, C_FETCH); cyc("ill.d", 4'd1, C_ILL);
    set_ins(6'b000000, 6'b000000);
    cyc("illr.f", 4'd0, C_FETCH); cyc("illr.d", 4'd1, C_ILL);
    chk("ill.state", {28'b0, state}, 32'd0);
    chk("ill.instret", instret, exp_ret);

    // reset during MW: no write, no retire, counter cleared
    set_ins(6'b101011, 6'b0);
    cyc("swr.f", 4'd0, C_FETCH); cyc("swr.d", 4'd1, C_NONE); cyc("swr.ma", 4'd2, C_MA);
    chk("swr.mw_state", {28'b0, state}, 32'd4);
    reset = 1'b1;
    #1;
    chk("swr.mw_ctl", ctl, C_NONE);
    chk("swr.memwr", {31'b0, memwr}, 32'd0);
    tick();
    chk("swr.state", {28'b0, state}, 32'd0);
    chk("swr.instret", instret, 32'd0);
    exp_ret = 0;
    reset = 1'b0;
    #1;

    // 15 jumps bring the 4-bit counter to its max value; one more wraps it to 0
    set_ins(6'b000010, 6'b0);
    for (int i = 0; i < 15; i++) begin
      tick(); tick(); tick();
    end
    exp_ret = 15;
    chk("wrap.pre4", {28'b0, instret1}, 32'd15);
    chk("wrap.pre32", instret, exp_ret);
    cyc("wrap.f", 4'd0, C_FETCH); cyc("wrap.d", 4'd1, C_NONE); cyc("wrap.j", 4'd9, C_J);
    exp_ret++;
    chk("wrap.post4", {28'b0, instret1}, 32'd0);
    chk("wrap.post32", instret, exp_ret);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
